// File: rtl/kbd_iot_ctrl.sv
// kbd_iot_ctrl: KL8E keyboard controller that buffers receiver characters in a FIFO and answers PDP-8 IOTs.
module kbd_iot_ctrl #(
  parameter logic [5:0] DEVICE = 6'o03,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        rx_flag,
  input  logic [0:7]  rx_char,
  output logic        rx_clear_flag,
  input  logic        iot_strobe,
  input  logic [0:5]  iot_device,
  input  logic [0:2]  iot_op,
  input  logic [0:11] ac_in,
  output logic        iot_ack,
  output logic        skip,
  output logic        ac_clear,
  output logic        ac_or,
  output logic [0:11] ac_out,
  output logic        kbd_flag,
  output logic        int_req,
  output logic        overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic WAIT_FLAG = 1'b0;
  localparam logic WAIT_DROP = 1'b1;
  logic          state, ie, rst, accept, capture, full, pop, push, rd_op, unused_ac;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  assign rst       = reset | clear;
  assign unused_ac = ^ac_in[0:10];
  assign accept    = iot_strobe && iot_device == DEVICE;
  assign kbd_flag  = count != '0;
  assign int_req   = ie & kbd_flag;
  assign full      = count == (AW+1)'(FIFO_DEPTH);
  assign head      = kbd_flag ? mem[rd_ptr] : 8'h00;
  assign rd_op     = iot_op == 3'd4 || iot_op == 3'd6;
  assign pop       = accept && (iot_op == 3'd0 || iot_op == 3'd2 || iot_op == 3'd6) && kbd_flag;
  assign capture   = state == WAIT_FLAG && rx_flag;
  // a full FIFO still accepts the new character when the head leaves in the same cycle
  assign push      = capture && (!full || pop);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= rx_char;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_FLAG;
      rx_clear_flag <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overrun       <= 1'b0;
      ie            <= 1'b1;
      iot_ack       <= 1'b0;
      skip          <= 1'b0;
      ac_clear      <= 1'b0;
      ac_or         <= 1'b0;
      ac_out        <= '0;
    end else begin
      state         <= capture ? WAIT_DROP : (state == WAIT_DROP && !rx_flag) ? WAIT_FLAG : state;
      rx_clear_flag <= capture;
      wr_ptr        <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr        <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count         <= count + (AW+1)'(push) - (AW+1)'(pop);
      overrun       <= (overrun && !(accept && iot_op == 3'd2)) || (capture && full && !pop);
      ie            <= (accept && iot_op == 3'd5) ? ac_in[11] : ie;
      iot_ack       <= accept;
      skip          <= accept && iot_op == 3'd1 && kbd_flag;
      ac_clear      <= accept && (iot_op == 3'd2 || iot_op == 3'd6);
      ac_or         <= accept && rd_op;
      ac_out        <= (accept && rd_op) ? {4'b0000, head} : 12'o0000;
    end
  end
endmodule
